// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer: two combinational lookup ports, one
// synchronous update port, per-entry 2-bit direction counters, round-robin eviction.
module btb_set_assoc #(
  parameter int SETS  = 256,
  parameter int WAYS  = 2,
  parameter int TAG_W = 30 - $clog2(SETS)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] lk0_pc,
  input  logic [31:0] lk1_pc,
  output logic        lk0_hit,
  output logic        lk0_taken,
  output logic [31:0] lk0_target,
  output logic        lk1_hit,
  output logic        lk1_taken,
  output logic [31:0] lk1_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_jump
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [1:0]       ctr_q   [SETS][WAYS];
  logic [31:0]      tgt_q   [SETS][WAYS];

  // Lookup ports: pure combinational reads of the current (pre-update) arrays.
  logic [31:0]        lk_pc  [2];
  logic [INDEX_W-1:0] lk_idx [2];
  logic [TAG_W-1:0]   lk_tag [2];
  logic [1:0]         lk_hit;
  logic [1:0]         lk_taken;
  logic [31:0]        lk_tgt [2];

  assign lk_pc[0] = lk0_pc;
  assign lk_pc[1] = lk1_pc;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_idx[p]   = lk_pc[p][1+INDEX_W:2];
      lk_tag[p]   = lk_pc[p][31:2+INDEX_W];
      lk_hit[p]   = 1'b0;
      lk_taken[p] = 1'b0;
      lk_tgt[p]   = lk_pc[p] + 32'd8;
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[lk_idx[p]][w] && (tag_q[lk_idx[p]][w] == lk_tag[p])) begin
          lk_hit[p]   = 1'b1;
          lk_taken[p] = ctr_q[lk_idx[p]][w][1];
          lk_tgt[p]   = tgt_q[lk_idx[p]][w];
        end
      end
    end
  end

  assign lk0_hit    = lk_hit[0];
  assign lk0_taken  = lk_taken[0];
  assign lk0_target = lk_tgt[0];
  assign lk1_hit    = lk_hit[1];
  assign lk1_taken  = lk_taken[1];
  assign lk1_target = lk_tgt[1];

  // Update handshake: upd_valid has no ready; a request is consumed at the
  // posedge where upd_valid & ~stall & ~flush, otherwise it is simply dropped.
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_en;
  logic               upd_hit;
  logic               has_inv;
  logic               evict;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   victim;
  logic [1:0]         old_ctr;
  logic [1:0]         new_ctr;

  assign upd_idx = upd_pc[1+INDEX_W:2];
  assign upd_tag = upd_pc[31:2+INDEX_W];
  assign upd_en  = upd_valid & ~stall & ~flush;

  always_comb begin
    upd_hit = 1'b0;
    has_inv = 1'b0;
    hit_way = '0;
    inv_way = '0;
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[upd_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    evict   = ~upd_hit & ~has_inv;
    victim  = upd_hit ? hit_way : (has_inv ? inv_way : rr_q[upd_idx]);
    old_ctr = ctr_q[upd_idx][hit_way];
    if (upd_is_jump)
      new_ctr = 2'b11;
    else if (upd_hit)
      new_ctr = upd_taken ? ((old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'b01)
                          : ((old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'b01);
    else
      new_ctr = upd_taken ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (upd_en) begin
      valid_q[upd_idx][victim] <= 1'b1;
      if ((WAYS > 1) && evict)
        rr_q[upd_idx] <= rr_q[upd_idx] + WAY_W'(1);
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (!upd_hit)
        tag_q[upd_idx][victim] <= upd_tag;
      tgt_q[upd_idx][victim] <= upd_target;
      ctr_q[upd_idx][victim] <= new_ctr;
    end
  end
endmodule

// File: tb/tb_btb_set_assoc.sv
// Randomised scoreboard bench for btb_set_assoc against a word-address keyed model.
module tb_btb_set_assoc;
  localparam int SETS = 256;
  localparam int WAYS = 2;
  localparam int IW   = $clog2(SETS);
  localparam int W    = 68;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] lk0_pc = '0, lk1_pc = '0;
  logic        lk0_hit, lk0_taken, lk1_hit, lk1_taken;
  logic [31:0] lk0_target, lk1_target;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_is_jump = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;

  btb_set_assoc #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .lk0_pc(lk0_pc), .lk1_pc(lk1_pc),
    .lk0_hit(lk0_hit), .lk0_taken(lk0_taken), .lk0_target(lk0_target),
    .lk1_hit(lk1_hit), .lk1_taken(lk1_taken), .lk1_target(lk1_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: each entry keyed by the full word address pc[31:2].
  bit          mv   [SETS][WAYS];
  logic [29:0] mkey [SETS][WAYS];
  int          mctr [SETS][WAYS];
  logic [31:0] mtgt [SETS][WAYS];
  int          mrr  [SETS];

  logic [W-1:0] exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  chk_v  = 1'b0;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    end
  endtask

  function automatic logic [33:0] model_lookup(input logic [31:0] pc);
    int s = int'((pc >> 2) % SETS);
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mkey[s][w] == pc[31:2])
        return {1'b1, mctr[s][w] >= 2, mtgt[s][w]};
    return {2'b00, pc + 32'd8};
  endfunction

  task automatic model_update(input bit uv, input logic [31:0] upc, input bit ut,
                              input logic [31:0] utgt, input bit uj, input bit st, input bit fl);
    int s;
    int way;
    if (fl) begin
      model_clear();
      return;
    end
    if (!uv || st) return;
    s = int'((upc >> 2) % SETS);
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mkey[s][w] == upc[31:2]) way = w;
    if (way >= 0) begin
      mtgt[s][way] = utgt;
      if (uj) mctr[s][way] = 3;
      else if (ut) mctr[s][way] = (mctr[s][way] + 1 > 3) ? 3 : mctr[s][way] + 1;
      else mctr[s][way] = (mctr[s][way] - 1 < 0) ? 0 : mctr[s][way] - 1;
      return;
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!mv[s][w]) way = w;
    if (way < 0) begin
      way = mrr[s];
      mrr[s] = (mrr[s] + 1) % WAYS;
    end
    mv[s][way]   = 1'b1;
    mkey[s][way] = upc[31:2];
    mtgt[s][way] = utgt;
    mctr[s][way] = uj ? 3 : (ut ? 2 : 1);
  endtask

  // Driver: one cycle of stimulus; expected lookup reflects pre-update state.
  task automatic cycle(input logic [31:0] p0, input logic [31:0] p1, input bit uv,
                       input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                       input bit uj, input bit st, input bit fl);
    @(posedge clk); #1;
    lk0_pc = p0; lk1_pc = p1;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_is_jump = uj; stall = st; flush = fl;
    exp_q.push_back({model_lookup(p0), model_lookup(p1)});
    chk_v = 1'b1;
    model_update(uv, upc, ut, utgt, uj, st, fl);
  endtask

  task automatic look(input logic [31:0] p0, input logic [31:0] p1);
    cycle(p0, p1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] p0, input logic [31:0] upc, input bit ut,
                     input logic [31:0] utgt, input bit uj);
    cycle(p0, p0, 1'b1, upc, ut, utgt, uj, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'h8000_0000 | (32'($urandom_range(0, 3)) << (2 + IW)) | (32'($urandom_range(0, 3)) << 2);
    return pc;
  endfunction

  // Monitor: lookups are valid every driven cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard_underflow: no expected entry for a presented lookup");
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({lk0_hit, lk0_taken, lk0_target} !== e[67:34]) begin
          errors++;
          $display("FAIL lk0 pc=%h: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                   lk0_pc, lk0_hit, lk0_taken, lk0_target, e[67], e[66], e[65:34]);
        end
        checks++;
        if ({lk1_hit, lk1_taken, lk1_target} !== e[33:0]) begin
          errors++;
          $display("FAIL lk1 pc=%h: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                   lk1_pc, lk1_hit, lk1_taken, lk1_target, e[33], e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    look(32'hBFC0_0000, 32'hBFC0_0000);
    // Allocate taken, then two not-taken steps down the counter
    upd(32'hBFC0_0000, 32'h8000_1000, 1'b1, 32'h8000_2000, 1'b0);
    upd(32'h8000_1000, 32'h8000_1000, 1'b0, 32'h8000_3000, 1'b0);
    upd(32'h8000_1000, 32'h8000_1000, 1'b0, 32'h8000_3000, 1'b0);
    look(32'h8000_1000, 32'h8000_1004);
    // Jump forces counter to 3; stalled update changes nothing
    upd(32'h8000_1000, 32'h8000_1000, 1'b0, 32'h8000_4000, 1'b1);
    cycle(32'h8000_1000, 32'h8000_1000, 1'b1, 32'h8000_1000, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    look(32'h8000_1000, 32'h8000_1000);
    // Flush beats a same-cycle update
    cycle(32'h8000_1000, 32'h8000_5000, 1'b1, 32'h8000_5000, 1'b1, 32'h8000_6000, 1'b0, 1'b0, 1'b1);
    look(32'h8000_1000, 32'h8000_5000);
    // Three tags into one set: third evicts way0
    upd(32'h8000_0400, 32'h8000_0400, 1'b1, 32'h0000_0400, 1'b0);
    upd(32'h8000_0400, 32'h8000_0800, 1'b1, 32'h0000_0800, 1'b0);
    upd(32'h8000_0800, 32'h8000_0C00, 1'b0, 32'h0000_0C00, 1'b0);
    look(32'h8000_0400, 32'h8000_0800);
    look(32'h8000_0C00, 32'h8000_0C00);
    // Same-cycle update/lookup shows old data; pc+8 wraps
    cycle(32'h8000_0800, 32'hFFFF_FFFC, 1'b1, 32'h8000_0800, 1'b0, 32'h0000_0888, 1'b0, 1'b0, 1'b0);
    look(32'h8000_0800, 32'hFFFF_FFFC);

    // Reset in the middle of an update: update is lost
    @(posedge clk); #1;
    chk_v = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h8000_3000; upd_taken = 1'b1; upd_target = 32'h8000_7000;
    upd_is_jump = 1'b0; stall = 1'b0; flush = 1'b0;
    #2 resetn = 1'b0;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    resetn = 1'b1;
    model_clear();
    look(32'h8000_3000, 32'h8000_0800);

    // Randomised traffic concentrated on a few sets
    for (int i = 0; i < 800; i++) begin
      logic [31:0] p0, p1, upc, utgt;
      bit uv, ut, uj, st, fl;
      p0   = rand_pc();
      p1   = ($urandom_range(0, 3) == 0) ? p0 : rand_pc();
      if ($urandom_range(0, 15) == 0) p1 = 32'hFFFF_FFFC;
      upc  = ($urandom_range(0, 3) == 0) ? p0 : rand_pc();
      utgt = $urandom;
      uv   = ($urandom_range(0, 3) != 0);
      ut   = $urandom_range(0, 1) == 1;
      uj   = ($urandom_range(0, 5) == 0);
      st   = ($urandom_range(0, 7) == 0);
      fl   = ($urandom_range(0, 59) == 0);
      cycle(p0, p1, uv, upc, ut, utgt, uj, st, fl);
    end

    @(posedge clk); #1;
    chk_v = 1'b0;
    upd_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
